// File: rtl/ifns_pkg.sv
// Shared IFNS code constants: Fibonacci wire weights and the crosstalk pattern test.
// The encoder core and the receive-side decoder both build on these definitions.
package ifns_pkg;

  localparam int IFNS_CODE_W = 18;
  localparam int IFNS_DATA_W = 13;
  localparam int IFNS_SUM_W  = 15;

  // d1..d17 carry F(1)..F(17); d18 carries F(19) so the two codebook halves tile 0..8361
  localparam int unsigned IFNS_W [1:18] = '{
    1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 1597, 4181
  };

  function automatic logic is_forbidden3(input logic [2:0] p);
    return (p == 3'b010) || (p == 3'b101);
  endfunction

endpackage

// File: rtl/ifns_wsum.sv
// Combinational partial weighted sum over codeword bits START..STOP.
// The port carries only the slice it sums, so every input bit is used.
module ifns_wsum
  import ifns_pkg::*;
#(
  parameter int START = 1,
  parameter int STOP  = IFNS_CODE_W,
  parameter int SUM_W = IFNS_SUM_W
) (
  input  logic [STOP:START] code_i,
  output logic [SUM_W-1:0]  sum_o
);

  always_comb begin
    sum_o = '0;
    for (int k = START; k <= STOP; k++) begin
      if (code_i[k]) sum_o = sum_o + SUM_W'(IFNS_W[k]);
    end
  end

endmodule

// File: rtl/ifns_decoder_18.sv
// IFNS 18-wire to 13-bit decoder: two-stage pipeline with valid/ready flow control,
// forbidden-pattern / range error flagging and a saturating error counter.
module ifns_decoder_18
  import ifns_pkg::*;
#(
  parameter int DATA_W   = IFNS_DATA_W,
  parameter int CODE_W   = IFNS_CODE_W,
  parameter int ERR_W    = 8,
  parameter int FP_CHECK = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [CODE_W:1]   codein,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              code_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);

  localparam int SPLIT = 9;

  logic                  en;
  logic                  accept;
  logic [IFNS_SUM_W-1:0] lo_sum;
  logic [IFNS_SUM_W-1:0] hi_sum;
  logic                  pat_err_d;
  logic [IFNS_SUM_W-1:0] lo_q;
  logic [IFNS_SUM_W-1:0] hi_q;
  logic                  pat_q;
  logic                  a_valid_q;
  logic [IFNS_SUM_W-1:0] sum;
  logic                  range_err;
  logic [DATA_W-1:0]     dataout_q;
  logic                  code_err_q;
  logic                  out_valid_q;
  logic [ERR_W-1:0]      err_cnt_q;
  logic [ERR_W-1:0]      err_cnt_d;

  // A held output word freezes the whole pipe
  assign en       = ~out_valid_q | out_ready;
  assign accept   = in_valid & en;
  assign in_ready = en;

  ifns_wsum #(.START(1), .STOP(SPLIT)) u_wsum_lo (
    .code_i (codein[SPLIT:1]),
    .sum_o  (lo_sum)
  );

  ifns_wsum #(.START(SPLIT + 1), .STOP(CODE_W)) u_wsum_hi (
    .code_i (codein[CODE_W:SPLIT+1]),
    .sum_o  (hi_sum)
  );

  always_comb begin
    pat_err_d = 1'b0;
    for (int k = 1; k <= CODE_W - 2; k++) begin
      pat_err_d = pat_err_d | is_forbidden3(codein[k+2 -: 3]);
    end
    pat_err_d = pat_err_d & (FP_CHECK != 0);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      hi_q      <= '0;
      pat_q     <= 1'b0;
      a_valid_q <= 1'b0;
    end else if (en) begin
      lo_q      <= lo_sum;
      hi_q      <= hi_sum;
      pat_q     <= pat_err_d;
      a_valid_q <= accept;
    end
  end

  assign sum       = lo_q + hi_q;
  assign range_err = |sum[IFNS_SUM_W-1:DATA_W];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q   <= '0;
      code_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      dataout_q   <= sum[DATA_W-1:0];
      code_err_q  <= pat_q | range_err;
      out_valid_q <= a_valid_q;
    end
  end

  // Clear wins over a same-cycle errored delivery
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q & out_ready & code_err_q & ~(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign dataout   = dataout_q;
  assign code_err  = code_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ifns_decoder_18.sv
// Self-checking bench for ifns_decoder_18: table vectors, directed corner sequences and a
// randomized stream scored against a codebook model built by enumerating FP-free codewords.
module tb_ifns_decoder_18;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [18:1] codein;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] dataout;
  logic        code_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;
  logic        err_clr;

  always #5 clock = ~clock;

  ifns_decoder_18 dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .codein    (codein),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .code_err  (code_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          w [1:18];
  logic [18:1] enc_tab [0:8191];
  logic [18:1] exp_q [$];
  int          mdl_cnt = 0;
  int          n_deliv = 0;
  bit          stall_prev = 0;
  logic [12:0] held_data;
  logic        held_err;
  logic [18:1] mon_cw;
  int          mon_v;
  bit          mon_e;

  typedef struct {
    string       name;
    logic [18:1] cw;
    logic [12:0] data;
    logic        err;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_value(input logic [18:1] cw);
    int s = 0;
    for (int k = 1; k <= 18; k++) if (cw[k]) s += w[k];
    return s;
  endfunction

  // Forbidden = any three adjacent wires that alternate
  function automatic bit ref_forbidden(input logic [18:1] cw);
    for (int k = 1; k <= 16; k++) begin
      if (cw[k] != cw[k+1] && cw[k+1] != cw[k+2]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit ref_err(input logic [18:1] cw);
    return ref_forbidden(cw) || (ref_value(cw) > 8191);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt    = 0;
      stall_prev = 0;
    end else begin
      chk("err_cnt", err_cnt, mdl_cnt);
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        if (stall_prev) begin
          chk("hold_data", dataout, held_data);
          chk("hold_err", code_err, held_err);
        end
        stall_prev = 1;
        held_data  = dataout;
        held_err   = code_err;
      end else begin
        chk("in_ready_free", in_ready, 1);
        stall_prev = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          mon_cw = exp_q.pop_front();
          mon_v  = ref_value(mon_cw);
          mon_e  = ref_err(mon_cw);
          chk("dataout", dataout, mon_v % 8192);
          chk("code_err", code_err, mon_e);
          n_deliv++;
          if (mon_e && mdl_cnt < 255) mdl_cnt++;
        end
      end
      if (err_clr) mdl_cnt = 0;
      if (in_valid && in_ready) exp_q.push_back(codein);
    end
  end

  initial begin
    int          fa, fb, fc;
    int          idx, cyc, sent, base;
    bit          took;
    logic [18:1] t;
    int          rt_vals [5];
    int          st_vals [4];

    rst_n     = 1'b0;
    codein    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    fa = 1; fb = 1;
    w[1] = 1; w[2] = 1;
    for (int k = 3; k <= 19; k++) begin
      fc = fa + fb; fa = fb; fb = fc;
      if (k <= 17) w[k] = fc;
      if (k == 19) w[18] = fc;
    end
    for (int c = 0; c < (1 << 18); c++) begin
      t = 18'(c);
      if (!ref_forbidden(t) && ref_value(t) < 8192) enc_tab[ref_value(t)] = t;
    end

    tab[0] = '{"zero",       18'h00000,       13'h0000, 1'b0};
    tab[1] = '{"one",        enc_tab[1],      13'h0001, 1'b0};
    tab[2] = '{"x0aaa",      enc_tab[13'h0AAA], 13'h0AAA, 1'b0};
    tab[3] = '{"max_in",     enc_tab[13'h1FFF], 13'h1FFF, 1'b0};
    tab[4] = '{"pat010",     18'h00002,       13'd1,    1'b1};
    tab[5] = '{"pat101",     18'h00005,       13'd3,    1'b1};
    tab[6] = '{"all_ones",   18'h3FFFF,       13'd169,  1'b1};
    tab[7] = '{"top_only",   18'h20000,       13'd4181, 1'b0};
    tab[8] = '{"range_hi",   18'h3FFFE,       13'd168,  1'b1};

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_code_err", code_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    codein = 18'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_data", dataout, 0);
    chk("first_err", code_err, 0);
    chk("first_cnt", err_cnt, 0);
    tick();

    foreach (tab[i]) begin
      codein = tab[i].cw; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk({"tab_valid_", tab[i].name}, out_valid, 1);
      chk({"tab_data_", tab[i].name}, dataout, tab[i].data);
      chk({"tab_err_", tab[i].name}, code_err, tab[i].err);
      tick();
    end

    rt_vals = '{13'h0000, 13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF};
    for (int i = 0; i < 5; i++) begin
      codein = enc_tab[rt_vals[i]]; in_valid = 1'b1;
      tick();
      if (i >= 1) begin
        chk("rt_valid", out_valid, 1);
        chk("rt_data", dataout, rt_vals[i-1]);
        chk("rt_err", code_err, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("rt_valid_last", out_valid, 1);
    chk("rt_data_last", dataout, rt_vals[4]);
    tick();

    idx = 0; cyc = 0;
    while (idx < 8192 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      codein    = enc_tab[idx];
      @(negedge clock);
      took = in_valid && in_ready;
      tick();
      if (took) idx++;
      cyc++;
    end
    chk("sweep_budget", idx, 8192);

    for (int i = 0; i < 400; i++) begin
      codein    = 18'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    err_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", exp_q.size(), 0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    codein = 18'h00002; in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_five", err_cnt, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_err", code_err, 1);
    chk("clr_pre_cnt", err_cnt, 5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_wins", err_cnt, 0);
    tick();
    chk("clr_stays", err_cnt, 0);

    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("cnt_one", err_cnt, 1);
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_sat", err_cnt, 8'hFF);

    st_vals = '{13'h0123, 13'h1000, 13'h0F0F, 13'h1ABC};
    base = n_deliv; sent = 0;
    for (int c = 1; c <= 14; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 4);
      codein    = enc_tab[st_vals[(sent < 4) ? sent : 3]];
      @(negedge clock);
      took = in_valid && in_ready;
      if (c == 4) chk("stall_in_ready", in_ready, 0);
      tick();
      if (took) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_sent", sent, 4);
    chk("stall_delivered", n_deliv - base, 4);
    chk("stall_queue", exp_q.size(), 0);

    codein = enc_tab[100]; in_valid = 1'b1;
    tick();
    codein = enc_tab[200];
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", dataout, 0);
    chk("mid_rst_err", code_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", out_valid, 0);
    codein = enc_tab[300]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", dataout, 300);
    repeat (3) tick();
    chk("post_rst_valid_gone", out_valid, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
